// File: rtl/bpuf_pkg.sv
// Shared PUF block definitions: constant clog2 and the mem_writer state encoding.
package bpuf_pkg;

  // Ceiling log2 for parameter elaboration; clog2(1) == 0.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    int unsigned v;
    r = 0;
    v = (n > 0) ? n - 1 : 0;
    while (v > 0) begin
      v = v >> 1;
      r = r + 1;
    end
    return r;
  endfunction

  localparam int unsigned MW_STATE_W = 3;

  localparam logic [MW_STATE_W-1:0] MW_IDLE   = 3'd0;
  localparam logic [MW_STATE_W-1:0] MW_SHIFT  = 3'd1;
  localparam logic [MW_STATE_W-1:0] MW_STROBE = 3'd2;
  localparam logic [MW_STATE_W-1:0] MW_HOLD   = 3'd3;
  localparam logic [MW_STATE_W-1:0] MW_DONE   = 3'd4;

  typedef enum logic [MW_STATE_W-1:0] {
    ST_IDLE   = MW_IDLE,
    ST_SHIFT  = MW_SHIFT,
    ST_STROBE = MW_STROBE,
    ST_HOLD   = MW_HOLD,
    ST_DONE   = MW_DONE
  } mw_state_e;

endpackage

// File: rtl/mem_writer_sipo.sv
// Serial-in parallel-out word assembler: LSB-first shift register plus bit counter.
module mem_writer_sipo
  import bpuf_pkg::*;
#(
  parameter int unsigned C_WORDSIZE = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  shift_en_i,
  input  logic                  clear_i,
  input  logic                  bit_i,
  output logic [C_WORDSIZE-1:0] word_c,
  output logic                  full_c
);

  localparam int unsigned CNT_W = clog2(C_WORDSIZE);

  // Only W-1 bits are stored; the incoming bit completes the word combinationally.
  logic [C_WORDSIZE-2:0] sh_q, sh_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;

  always_comb begin
    word_c = {bit_i, sh_q};
    full_c = shift_en_i && (cnt_q == CNT_W'(C_WORDSIZE - 1));
    sh_d   = sh_q;
    cnt_d  = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (shift_en_i) begin
      sh_d  = word_c[C_WORDSIZE-1:1];
      cnt_d = full_c ? '0 : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sh_q  <= '0;
      cnt_q <= '0;
    end else begin
      sh_q  <= sh_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mem_writer.sv
// Fills the response memory from the PUF bit stream, one word per write-clock strobe.
module mem_writer
  import bpuf_pkg::*;
#(
  parameter int unsigned C_WORDSIZE = 8,
  parameter int unsigned C_MEMSIZE  = 4096,
  parameter int unsigned C_ADDRSIZE = clog2(C_MEMSIZE)
) (
  input  logic                  I_clk,
  input  logic                  I_rst,
  input  logic                  I_start,
  input  logic                  I_bit,
  input  logic                  I_bit_valid,
  output logic                  O_bit_ready,
  output logic [C_WORDSIZE-1:0] O_data,
  output logic [C_ADDRSIZE-1:0] O_addr,
  output logic                  O_wrclk,
  output logic                  O_busy,
  output logic                  O_done
);

  mw_state_e             state_q, state_d;
  logic [C_ADDRSIZE-1:0] addr_q, addr_d;
  logic [C_WORDSIZE-1:0] data_q, data_d;
  logic                  wrclk_q, wrclk_d;
  logic                  ready_q, ready_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  logic                  shift_en;
  logic                  sipo_clear;
  logic [C_WORDSIZE-1:0] word_c;
  logic                  full_c;

  mem_writer_sipo #(
    .C_WORDSIZE(C_WORDSIZE)
  ) u_sipo (
    .clk_i      (I_clk),
    .rst_i      (I_rst),
    .shift_en_i (shift_en),
    .clear_i    (sipo_clear),
    .bit_i      (I_bit),
    .word_c     (word_c),
    .full_c     (full_c)
  );

  // Outputs are computed for the next state and registered alongside it.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    data_d     = data_q;
    wrclk_d    = 1'b0;
    ready_d    = 1'b0;
    busy_d     = 1'b1;
    done_d     = 1'b0;
    sipo_clear = 1'b0;
    shift_en   = ready_q && I_bit_valid;

    case (state_q)
      ST_IDLE: begin
        sipo_clear = 1'b1;
        busy_d     = 1'b0;
        if (I_start) begin
          state_d = ST_SHIFT;
          addr_d  = '0;
          ready_d = 1'b1;
          busy_d  = 1'b1;
        end
      end
      ST_SHIFT: begin
        ready_d = 1'b1;
        if (full_c) begin
          state_d = ST_STROBE;
          data_d  = word_c;
          wrclk_d = 1'b1;
          ready_d = 1'b0;
        end
      end
      ST_STROBE: begin
        state_d = ST_HOLD;
      end
      ST_HOLD: begin
        // The memory committed on entry to HOLD; advance or finish.
        if (addr_q == C_ADDRSIZE'(C_MEMSIZE - 1)) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end else begin
          state_d    = ST_SHIFT;
          addr_d     = addr_q + C_ADDRSIZE'(1);
          sipo_clear = 1'b1;
          ready_d    = 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge I_clk or posedge I_rst) begin
    if (I_rst) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      wrclk_q <= 1'b0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      wrclk_q <= wrclk_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign O_bit_ready = ready_q;
  assign O_data      = data_q;
  assign O_addr      = addr_q;
  assign O_wrclk     = wrclk_q;
  assign O_busy      = busy_q;
  assign O_done      = done_q;

endmodule

// File: tb/tb_mem_writer.sv
// Bench for mem_writer (8-bit words, 4-word memory) with a negedge memory model and write scoreboard.
module tb_mem_writer;

  localparam int unsigned W  = 8;
  localparam int unsigned M  = 4;
  localparam int unsigned AW = 2;

  logic          clk = 1'b0;
  logic          I_rst = 1'b0;
  logic          I_start = 1'b0;
  logic          I_bit = 1'b0;
  logic          I_bit_valid = 1'b0;
  logic          O_bit_ready;
  logic [W-1:0]  O_data;
  logic [AW-1:0] O_addr;
  logic          O_wrclk;
  logic          O_busy;
  logic          O_done;

  mem_writer #(
    .C_WORDSIZE(W),
    .C_MEMSIZE (M),
    .C_ADDRSIZE(AW)
  ) dut (
    .I_clk       (clk),
    .I_rst       (I_rst),
    .I_start     (I_start),
    .I_bit       (I_bit),
    .I_bit_valid (I_bit_valid),
    .O_bit_ready (O_bit_ready),
    .O_data      (O_data),
    .O_addr      (O_addr),
    .O_wrclk     (O_wrclk),
    .O_busy      (O_busy),
    .O_done      (O_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [W-1:0]  data;
  } wr_t;

  typedef struct {
    logic [31:0] words;      // word k in bits [8k +: 8]
    bit          gaps;       // random I_bit_valid gaps
    int          start_at;   // bit index at which I_start is also pulsed (-1 none)
    bit          poke_done;  // pulse I_start while in DONE
    int          exp_lat;    // start-raise to done edges, <=0 to skip
  } vec_t;

  int          n_checks = 0;
  int          n_err = 0;
  int          n_writes = 0;
  int          cyc = 0;
  int          hi_cnt = 0;
  int          hi_base = 0;
  int          done_seen = 0;
  logic [AW-1:0] rise_addr = '0;
  logic [W-1:0]  mem [M];
  wr_t         sb[$];
  vec_t        tbl[5];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  task automatic fail_now(input string nm);
    n_checks++;
    n_err++;
    $display("FAIL %s: timeout", nm);
  endtask

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (O_wrclk) hi_cnt++;
    if (O_done) done_seen++;
  end

  always @(posedge O_wrclk) begin
    rise_addr = O_addr;
    hi_base   = hi_cnt;
  end

  // Negedge-committing memory model; each commit is matched against the scoreboard.
  always @(negedge O_wrclk) begin
    wr_t e;
    mem[O_addr] = O_data;
    n_writes++;
    if (!I_rst) begin
      chk("wrclk high cycles", 32'(hi_cnt - hi_base), 32'd1);
      chk("addr stable over strobe", 32'(O_addr), 32'(rise_addr));
    end
    if (sb.size() == 0) begin
      n_checks++;
      n_err++;
      $display("FAIL unexpected write: addr=%0h data=%0h", O_addr, O_data);
    end else begin
      e = sb.pop_front();
      chk("write addr", 32'(O_addr), 32'(e.addr));
      chk("write data", 32'(O_data), 32'(e.data));
    end
  end

  // Called at a negedge; offers one bit until accepted, returns at the negedge after acceptance.
  task automatic send_bit(input logic b, input bit gaps, input bit pulse_start);
    bit acc;
    int budget;
    acc = 1'b0;
    budget = 0;
    while (!acc) begin
      I_start = pulse_start;
      if (gaps && $urandom_range(0, 2) == 0) begin
        I_bit_valid = 1'b0;
        I_bit       = 1'($urandom_range(0, 1));
      end else begin
        I_bit_valid = 1'b1;
        I_bit       = b;
      end
      acc = I_bit_valid && O_bit_ready;
      @(negedge clk);
      budget++;
      if (!acc && budget > 200) begin
        fail_now("bit handshake");
        acc = 1'b1;
      end
    end
  endtask

  task automatic run_fill(input int vi);
    vec_t        v;
    logic [W-1:0] w;
    wr_t         e;
    int          s;
    int          dc;
    int          dbase;
    v = tbl[vi];
    dbase = done_seen;
    @(negedge clk);
    I_start = 1'b1;
    I_bit_valid = 1'b1;
    I_bit = v.words[0];
    s = cyc;
    @(negedge clk);
    I_start = 1'b0;
    chk($sformatf("v%0d ready after start", vi), 32'(O_bit_ready), 32'd1);
    chk($sformatf("v%0d busy after start", vi), 32'(O_busy), 32'd1);
    chk($sformatf("v%0d addr after start", vi), 32'(O_addr), 32'd0);
    for (int k = 0; k < int'(M); k++) begin
      w = v.words[8*k +: 8];
      e.addr = AW'(k);
      e.data = w;
      sb.push_back(e);
      for (int i = 0; i < int'(W); i++) send_bit(w[i], v.gaps, (8*k + i) == v.start_at);
    end
    I_bit_valid = 1'b0;
    I_start = 1'b0;
    dc = -1;
    for (int n = 0; n < 60 && dc < 0; n++) begin
      if (O_done) dc = cyc;
      else @(negedge clk);
    end
    if (dc < 0) begin
      fail_now($sformatf("v%0d done", vi));
    end else begin
      if (v.exp_lat > 0) chk($sformatf("v%0d done latency", vi), 32'(dc - s), 32'(v.exp_lat));
      chk($sformatf("v%0d addr in done", vi), 32'(O_addr), 32'(M - 1));
      if (v.poke_done) I_start = 1'b1;
      @(negedge clk);
      I_start = 1'b0;
      chk($sformatf("v%0d done one cycle", vi), 32'(O_done), 32'd0);
      chk($sformatf("v%0d busy after done", vi), 32'(O_busy), 32'd0);
      chk($sformatf("v%0d ready after done", vi), 32'(O_bit_ready), 32'd0);
      chk($sformatf("v%0d addr held", vi), 32'(O_addr), 32'(M - 1));
      @(negedge clk);
      @(negedge clk);
      chk($sformatf("v%0d still idle", vi), 32'(O_busy), 32'd0);
      chk($sformatf("v%0d done pulses", vi), 32'(done_seen - dbase), 32'd1);
    end
    for (int k = 0; k < int'(M); k++)
      chk($sformatf("v%0d mem[%0d]", vi, k), 32'(mem[k]), 32'(v.words[8*k +: 8]));
    chk($sformatf("v%0d pending writes", vi), 32'(sb.size()), 32'd0);
  endtask

  initial begin
    int   bad;
    logic [W-1:0] w;
    wr_t  e;

    tbl[0] = '{words: 32'hE10F5AC3, gaps: 1'b0, start_at: -1, poke_done: 1'b0, exp_lat: 41};
    tbl[1] = '{words: 32'h01FF3CA5, gaps: 1'b0, start_at: -1, poke_done: 1'b0, exp_lat: 41};
    tbl[2] = '{words: 32'h01FF3CA5, gaps: 1'b1, start_at: -1, poke_done: 1'b0, exp_lat: 0};
    tbl[3] = '{words: 32'h8E713C96, gaps: 1'b0, start_at: 4,  poke_done: 1'b1, exp_lat: 41};
    tbl[4] = '{words: 32'h5A0F7E24, gaps: 1'b1, start_at: 13, poke_done: 1'b1, exp_lat: 0};

    // Reset, then idle with no start.
    #2 I_rst = 1'b1;
    repeat (3) @(negedge clk);
    I_rst = 1'b0;
    chk("reset outputs", {23'd0, O_data, O_addr, O_wrclk, O_bit_ready, O_busy, O_done},
        32'd0);
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (O_busy || O_wrclk || O_bit_ready) bad++;
    end
    chk("idle outputs quiet", 32'(bad), 32'd0);
    chk("idle writes", 32'(n_writes), 32'd0);

    // Single word 0x0D, LSB first, with strobe timing.
    w = 8'h0D;
    e.addr = '0;
    e.data = w;
    sb.push_back(e);
    I_start = 1'b1;
    I_bit_valid = 1'b1;
    I_bit = w[0];
    @(negedge clk);
    I_start = 1'b0;
    for (int i = 0; i < int'(W); i++) send_bit(w[i], 1'b0, 1'b0);
    I_bit_valid = 1'b0;
    chk("strobe wrclk high", 32'(O_wrclk), 32'd1);
    chk("strobe data", 32'(O_data), 32'h0D);
    chk("strobe ready low", 32'(O_bit_ready), 32'd0);
    chk("strobe addr", 32'(O_addr), 32'd0);
    @(negedge clk);
    chk("hold wrclk low", 32'(O_wrclk), 32'd0);
    chk("hold addr", 32'(O_addr), 32'd0);
    chk("single word mem[0]", 32'(mem[0]), 32'h0D);
    @(negedge clk);
    chk("ready back", 32'(O_bit_ready), 32'd1);
    chk("addr advanced", 32'(O_addr), 32'd1);

    // Reset mid-fill after 12 bits total: no write, outputs cleared at once.
    for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b0, 1'b0);
    I_bit_valid = 1'b0;
    I_rst = 1'b1;
    #1;
    chk("mid-fill reset outputs", {23'd0, O_data, O_addr, O_wrclk, O_bit_ready, O_busy, O_done},
        32'd0);
    @(negedge clk);
    I_rst = 1'b0;
    chk("writes before refill", 32'(n_writes), 32'd1);

    // Table of full fills; entry 0 also confirms 0xC3 overwrites mem[0] after the reset.
    for (int vi = 0; vi < 5; vi++) run_fill(vi);

    chk("total writes", 32'(n_writes), 32'(1 + 5 * M));
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global timeout: got running, want finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mem_writer.md
# mem_writer

Fills the response memory from the PUF's serial bit stream. Accepts one bit per handshake, assembles bits into C_WORDSIZE-bit words, and writes each word through the memory's negedge-triggered write port (data, address, write clock) at consecutive addresses from 0 up to C_MEMSIZE-1. It sits directly upstream of the response memory, and its outputs connect straight to that memory's data, address and write-clock inputs.

## Interface
- C_WORDSIZE, 8, bits per memory word; must be ≥ 2
- C_MEMSIZE, 4096, words per fill; need not be a power of 2
- C_ADDRSIZE, clog2(C_MEMSIZE), address width
- I_clk  in  1  single system clock; all state updates on the rising edge
- I_rst  in  1  asynchronous reset, active-high
- I_start  in  1  one-cycle request to begin a fill at address 0
- I_bit  in  1  serial response bit
- I_bit_valid  in  1  I_bit is valid this cycle
- O_bit_ready  out  1  block accepts I_bit this cycle
- O_data  out  C_WORDSIZE  word to write; drives memory data input
- O_addr  out  C_ADDRSIZE  write address; drives memory address input
- O_wrclk  out  1  write strobe; the memory commits on its falling edge
- O_busy  out  1  fill in progress
- O_done  out  1  one-cycle pulse when the last word has been written

## Operation
- States: IDLE, SHIFT, STROBE, HOLD, DONE.
- IDLE:
  - I_start=1 → SHIFT.
  - Clears the address counter to 0 and the bit counter to 0.
- SHIFT:
  - O_bit_ready=1.
  - A bit is accepted when I_bit_valid && O_bit_ready.
  - Accepted bits are shifted right into the word register, entering at the MSB. The first accepted bit ends up in bit 0 (LSB-first).
  - On the C_WORDSIZE-th accepted bit, the completed word is loaded into O_data → STROBE.
- STROBE:
  - O_wrclk=1, O_bit_ready=0 → HOLD.
- HOLD:
  - O_wrclk=0. Its falling edge commits O_data at O_addr.
  - If O_addr == C_MEMSIZE-1 → DONE.
  - Otherwise O_addr increments, the bit counter clears → SHIFT.
- DONE:
  - O_done=1 for one cycle → IDLE.
  - O_addr holds C_MEMSIZE-1 until the next start.
- O_busy=1 in every state except IDLE.
- I_start is ignored outside IDLE, including in DONE.
- I_bit_valid is ignored outside SHIFT; no bit is lost because O_bit_ready=0 there.
- Width rules:
  - Address compare is against C_MEMSIZE-1; there is no wrap to 0 mid-fill.
  - Bit counter is clog2(C_WORDSIZE) bits wide and compares against C_WORDSIZE-1.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Timing
- Reset values: state IDLE, O_data 0, O_addr 0, O_wrclk 0, O_bit_ready 0, O_busy 0, O_done 0.
- Reset mid-fill:
  - All outputs are forced to their reset values immediately.
  - Reset asserted in STROBE produces a falling edge on O_wrclk. The memory therefore writes the already-complete word at the current address. This is accepted behaviour.
  - Reset in any other state causes no write.
  - Partially shifted bits are discarded.
- I_start accepted at edge t: O_bit_ready=1 and O_busy=1 from cycle t+1.
- Last bit of a word accepted at edge t:
  - O_data is valid and O_wrclk rises after edge t.
  - O_wrclk falls after edge t+1; the write commits then.
  - O_data and O_addr stay stable until edge t+2.
  - O_bit_ready reasserts after edge t+2.
- With I_bit_valid held high:
  - One word takes C_WORDSIZE+2 cycles.
  - A full fill takes C_MEMSIZE·(C_WORDSIZE+2)+1 cycles from start to the O_done pulse.
- Stalls: I_bit_valid low in SHIFT simply pauses the fill; no timeout.

## Structure
- Shared package bpuf_pkg holds:
  - the clog2 constant function, also used by the memory's parameter default;
  - state encoding localparams MW_IDLE, MW_SHIFT, MW_STROBE, MW_HOLD, MW_DONE.
- One sub-module is natural: mem_writer_sipo.
  - Contents: shift register plus bit counter.
  - Inputs: shift-enable and clear.
  - Outputs: word and word-complete flag.
  - The parent FSM owns the address counter and the strobe.

## Test plan
All scenarios use C_WORDSIZE=8 and C_MEMSIZE=4, with a behavioural negedge memory model attached.
- Reset then idle: no start for 20 cycles → O_busy=0, O_wrclk=0, O_bit_ready=0 throughout, and no memory writes.
- Single word, LSB-first: start, then bits 1,0,1,1,0,0,0,0 → mem[0]=0x0D. O_wrclk is high exactly one cycle, and O_addr=0 stays stable through the falling edge.
- Full fill:
  - Stimulus: 32 continuous bits giving words 0xA5, 0x3C, 0xFF, 0x01.
  - Expected: mem[0..3] hold those words.
  - Expected: O_done pulses exactly one cycle, 41 cycles after start.
  - Expected: O_busy then drops.
- Backpressure and gaps: I_bit_valid toggled randomly; bits offered during STROBE/HOLD are held by the source → same memory contents as the full-fill case, and no bit is dropped or duplicated.
- Start while busy: I_start pulsed mid-word and in DONE → ignored; addresses continue without restarting.
- Reset mid-fill: rst after 12 bits, then a fresh start with 0xC3 … → mem[0]=0xC3 overwrites, O_addr restarts at 0, and the partial bits are discarded.
